filter_div_arbiter: RTL and testbench

//  Shares one iterative divider between NUM_CH filter channels running in average mode.

---
 rtl/filter_div_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_filter_div_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_div_arbiter.sv
// filter_div_arbiter
//   Shares one iterative divider between NUM_CH filter channels in average mode.
//   Each channel posts a (sum, count) pair with a one-clock request. The pair is
//   latched into a per-channel slot, the divider is granted round-robin, and the
//   quotient is returned on out_o with a one-clock per-channel ready strobe.
//
//   Optional build macro FILTER_DIV_TMO_EN: adds a divider watchdog. If the
//   divider does not answer within TMO_CYC clocks of WAIT, the channel receives
//   0xFFFFFFFF and its div-by-zero/fault health bit is set. Without the macro,
//   WAIT holds until div_done_i.
//
// Ports
//   clk_i        system clock
//   reset_n_i    asynchronous active-low reset
//   req_i        per-channel request strobe (1 clk)
//   num_i/den_i  per-channel numerator/denominator, ch k at [k*W +: W]
//   div_start_o  1-clk start pulse to the divider
//   div_num_o    numerator to the divider, stable from start to done
//   div_den_o    denominator to the divider, stable from start to done
//   div_done_i   1-clk divider completion strobe
//   div_quot_i   divider quotient, valid with div_done_i
//   out_o        per-channel quotient, held until the next delivery
//   ready_o      per-channel 1-clk result-valid strobe
//   health_o     per channel: [0] div-by-zero / timeout, [1] request while pending
//
// state   | meaning
// IDLE    | no operation; picks the next pending channel from the RR pointer
// ISSUE   | grant latched; start the divider or short-circuit a zero divisor
// WAIT    | divider busy on the granted channel
// DELIVER | write quotient to the granted channel, advance the RR pointer

module filter_div_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int NUM_W   = 64,
  parameter int DEN_W   = 32,
  parameter int TMO_CYC = 128
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [NUM_CH-1:0]       req_i,
  input  logic [NUM_CH*NUM_W-1:0] num_i,
  input  logic [NUM_CH*DEN_W-1:0] den_i,
  output logic                    div_start_o,
  output logic [NUM_W-1:0]        div_num_o,
  output logic [DEN_W-1:0]        div_den_o,
  input  logic                    div_done_i,
  input  logic [31:0]             div_quot_i,
  output logic [NUM_CH*32-1:0]    out_o,
  output logic [NUM_CH-1:0]       ready_o,
  output logic [NUM_CH*2-1:0]     health_o
);

  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     gnt_q, gnt_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [31:0]         quot_q, quot_d;
  logic [NUM_CH-1:0]   pend_q;
  logic [NUM_W-1:0]    slot_num_q [NUM_CH];
  logic [DEN_W-1:0]    slot_den_q [NUM_CH];
  logic [NUM_CH*32-1:0] out_q;
  logic [NUM_CH-1:0]   ready_q;
  logic [NUM_CH*2-1:0] health_q;
  logic                err_set;
  logic [NUM_CH-1:0]   dlv_vec;
  logic [NUM_CH-1:0]   err_vec;

`ifdef FILTER_DIV_TMO_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`else
  // TMO_CYC has no role without the watchdog.
  logic                tmo_cyc_unused;
  assign tmo_cyc_unused = ^TMO_CYC;
`endif

  // First pending channel at or after the pointer, wrapping around.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] pend,
                                              input logic [CH_W-1:0]   ptr);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] cand_idx;
    logic            found;
    int              cand;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = CH_W'(cand);
      if (!found && pend[cand_idx]) begin
        pick  = cand_idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_d        = rr_q;
    quot_d      = quot_q;
    div_start_o = 1'b0;
    err_set     = 1'b0;
`ifdef FILTER_DIV_TMO_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          gnt_d   = rr_pick(pend_q, rr_q);
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (slot_den_q[gnt_q] == '0) begin
          quot_d  = '0;
          err_set = 1'b1;
          state_d = DELIVER;
        end else begin
          div_start_o = 1'b1;
          state_d     = WAIT;
`ifdef FILTER_DIV_TMO_EN
          tmo_d       = TMO_W'(TMO_CYC - 1);
`endif
        end
      end
      WAIT: begin
        if (div_done_i) begin
          quot_d  = div_quot_i;
          state_d = DELIVER;
        end
`ifdef FILTER_DIV_TMO_EN
        else if (tmo_q == '0) begin
          quot_d  = '1;
          err_set = 1'b1;
          state_d = DELIVER;
        end else begin
          tmo_d = tmo_q - TMO_W'(1);
        end
`endif
      end
      DELIVER: begin
        rr_d    = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + CH_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dlv_vec = '0;
    err_vec = '0;
    if (state_q == DELIVER) dlv_vec[gnt_q] = 1'b1;
    if (err_set)            err_vec[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      quot_q   <= '0;
      pend_q   <= '0;
      out_q    <= '0;
      ready_q  <= '0;
      health_q <= '0;
`ifdef FILTER_DIV_TMO_EN
      tmo_q    <= '0;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        slot_num_q[k] <= '0;
        slot_den_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      quot_q  <= quot_d;
      ready_q <= dlv_vec;
`ifdef FILTER_DIV_TMO_EN
      tmo_q   <= tmo_d;
`endif
      for (int k = 0; k < NUM_CH; k++) begin
        if (dlv_vec[k]) out_q[k*32 +: 32] <= quot_q;
        if (err_vec[k]) health_q[2*k] <= 1'b1;
        // A delivery frees the slot on the same edge, so a request arriving
        // then is accepted as a fresh one rather than flagged.
        if (req_i[k]) begin
          if (!pend_q[k] || dlv_vec[k]) begin
            slot_num_q[k] <= num_i[k*NUM_W +: NUM_W];
            slot_den_q[k] <= den_i[k*DEN_W +: DEN_W];
            pend_q[k]     <= 1'b1;
          end else begin
            health_q[2*k+1] <= 1'b1;
          end
        end else if (dlv_vec[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
    end
  end

  assign div_num_o = slot_num_q[gnt_q];
  assign div_den_o = slot_den_q[gnt_q];
  assign out_o     = out_q;
  assign ready_o   = ready_q;
  assign health_o  = health_q;

endmodule

// File: tb/tb_filter_div_arbiter.sv
module tb_filter_div_arbiter;
  localparam int NUM_CH = 4;
  localparam int NUM_W  = 64;
  localparam int DEN_W  = 32;

  logic                    clk_i = 1'b0;
  logic                    reset_n_i;
  logic [NUM_CH-1:0]       req_i;
  logic [NUM_CH*NUM_W-1:0] num_i;
  logic [NUM_CH*DEN_W-1:0] den_i;
  logic                    div_start_o;
  logic [NUM_W-1:0]        div_num_o;
  logic [DEN_W-1:0]        div_den_o;
  logic                    div_done_i;
  logic [31:0]             div_quot_i;
  logic [NUM_CH*32-1:0]    out_o;
  logic [NUM_CH-1:0]       ready_o;
  logic [NUM_CH*2-1:0]     health_o;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;

  filter_div_arbiter #(
    .NUM_CH (NUM_CH),
    .NUM_W  (NUM_W),
    .DEN_W  (DEN_W),
    .TMO_CYC(128)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .req_i      (req_i),
    .num_i      (num_i),
    .den_i      (den_i),
    .div_start_o(div_start_o),
    .div_num_o  (div_num_o),
    .div_den_o  (div_den_o),
    .div_done_i (div_done_i),
    .div_quot_i (div_quot_i),
    .out_o      (out_o),
    .ready_o    (ready_o),
    .health_o   (health_o)
  );

  always #5 clk_i = ~clk_i;

  // Start pulses are tallied shortly after each falling edge.
  always @(negedge clk_i) begin
    #1;
    if (div_start_o === 1'b1) start_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic post(input int k, input logic [63:0] n, input logic [31:0] d);
    req_i[k]                 = 1'b1;
    num_i[k*NUM_W +: NUM_W]  = n;
    den_i[k*DEN_W +: DEN_W]  = d;
  endtask

  task automatic do_reset();
    reset_n_i  = 1'b0;
    req_i      = '0;
    div_done_i = 1'b0;
    step(2);
    reset_n_i = 1'b1;
    step(1);
  endtask

  task automatic expect_start(input string tag, input logic [63:0] n, input logic [31:0] d);
    int i;
    i = 0;
    while (div_start_o !== 1'b1 && i < 20) begin
      @(negedge clk_i);
      i++;
    end
    chk($sformatf("%s_start", tag), div_start_o, 1);
    chk($sformatf("%s_num", tag), div_num_o, n);
    chk($sformatf("%s_den", tag), div_den_o, d);
  endtask

  // Called in the ISSUE cycle or later; returns in the DELIVER cycle.
  task automatic finish_div(input logic [31:0] q, input int lat);
    step(lat);
    div_done_i = 1'b1;
    div_quot_i = q;
    step(1);
    div_done_i = 1'b0;
    div_quot_i = '0;
  endtask

  task automatic expect_ready(input string tag, input int k, input logic [31:0] q);
    step(1);
    chk($sformatf("%s_ready", tag), ready_o, 128'd1 << k);
    chk($sformatf("%s_out", tag), out_o[k*32 +: 32], q);
    step(1);
    chk($sformatf("%s_ready_end", tag), ready_o, 0);
  endtask

  initial begin
    int            i;
    int            s;
    logic          saw_start;
    logic          seen;
    logic [3:0]    rdy_val;
    logic [31:0]   out2;

    reset_n_i  = 1'b0;
    req_i      = '0;
    num_i      = '0;
    den_i      = '0;
    div_done_i = 1'b0;
    div_quot_i = '0;
    step(2);
    chk("rst_start", div_start_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_out", out_o, 0);
    chk("rst_health", health_o, 0);
    reset_n_i = 1'b1;
    step(1);
    chk("rst_num", div_num_o, 0);

    // Single request with exact latencies.
    post(0, 64'd1000, 32'd10);
    step(1);
    req_i = '0;
    chk("t1_start_early", div_start_o, 0);
    step(1);
    chk("t1_start", div_start_o, 1);
    chk("t1_num", div_num_o, 1000);
    chk("t1_den", div_den_o, 10);
    step(1);
    chk("t1_start_pulse", div_start_o, 0);
    step(19);
    div_done_i = 1'b1;
    div_quot_i = 32'd100;
    step(1);
    div_done_i = 1'b0;
    div_quot_i = '0;
    chk("t1_ready_early", ready_o, 0);
    step(1);
    chk("t1_ready", ready_o, 4'b0001);
    chk("t1_out", out_o[31:0], 100);
    step(1);
    chk("t1_ready_end", ready_o, 0);
    chk("t1_out_hold", out_o[31:0], 100);
    chk("t1_health", health_o, 0);

    // All four channels at once: grants 0,1,2,3.
    do_reset();
    s = start_cnt;
    post(0, 64'd1000, 32'd10);
    post(1, 64'd2000, 32'd4);
    post(2, 64'd900,  32'd3);
    post(3, 64'd49,   32'd7);
    step(1);
    req_i = '0;
    expect_start("t2_c0", 1000, 10); finish_div(32'd100, 5); expect_ready("t2_c0", 0, 100);
    expect_start("t2_c1", 2000, 4);  finish_div(32'd500, 3); expect_ready("t2_c1", 1, 500);
    expect_start("t2_c2", 900, 3);   finish_div(32'd300, 4); expect_ready("t2_c2", 2, 300);
    expect_start("t2_c3", 49, 7);    finish_div(32'd7, 2);   expect_ready("t2_c3", 3, 7);
    step(2);
    chk("t2_start_count", start_cnt - s, 4);
    chk("t2_out_all", out_o, {32'd7, 32'd300, 32'd500, 32'd100});

    // Zero divisor on ch2.
    s = start_cnt;
    post(2, 64'd555, 32'd0);
    step(1);
    req_i     = '0;
    saw_start = 1'b0;
    rdy_val   = '0;
    out2      = 32'hDEAD_BEEF;
    for (int n = 0; n < 8; n++) begin
      step(1);
      if (div_start_o === 1'b1) saw_start = 1'b1;
      if (ready_o !== 4'b0000) begin
        rdy_val = ready_o;
        out2    = out_o[95:64];
      end
    end
    chk("t3_no_start", saw_start, 0);
    chk("t3_ready", rdy_val, 4'b0100);
    chk("t3_out", out2, 0);
    chk("t3_health", health_o, 8'h10);
    step(5);
    chk("t3_sticky", health_o, 8'h10);
    chk("t3_start_count", start_cnt - s, 0);

    // ch1 re-requests while pending.
    s = start_cnt;
    post(1, 64'd800, 32'd8);
    step(1);
    req_i = '0;
    expect_start("t4", 800, 8);
    step(3);
    post(1, 64'd999, 32'd3);
    step(1);
    req_i = '0;
    step(2);
    chk("t4_num_held", div_num_o, 800);
    chk("t4_den_held", div_den_o, 8);
    finish_div(32'd100, 2);
    expect_ready("t4", 1, 100);
    chk("t4_health", health_o, 8'h18);
    step(6);
    chk("t4_start_count", start_cnt - s, 1);

    // Fairness: ch0 re-requests in its delivery cycle while ch3 is pending.
    do_reset();
    post(0, 64'd10, 32'd1);
    step(1);
    req_i = '0;
    expect_start("t5_c0a", 10, 1);
    step(1);
    post(3, 64'd30, 32'd1);
    step(1);
    req_i = '0;
    step(2);
    div_done_i = 1'b1;
    div_quot_i = 32'd10;
    step(1);
    div_done_i = 1'b0;
    div_quot_i = '0;
    post(0, 64'd20, 32'd1);
    step(1);
    req_i = '0;
    chk("t5_ready0", ready_o, 4'b0001);
    expect_start("t5_c3", 30, 1);  finish_div(32'd30, 2); expect_ready("t5_c3", 3, 30);
    expect_start("t5_c0b", 20, 1); finish_div(32'd20, 2); expect_ready("t5_c0b", 0, 20);
    chk("t5_health", health_o, 0);

    // Divider that never answers.
    s = start_cnt;
    post(1, 64'd50, 32'd5);
    step(1);
    req_i = '0;
    expect_start("t6", 50, 5);
`ifdef FILTER_DIV_TMO_EN
    i = 0;
    while (ready_o === 4'b0000 && i < 200) begin
      step(1);
      i++;
    end
    chk("t6_tmo_cycles", i, 130);
    chk("t6_ready", ready_o, 4'b0010);
    chk("t6_out", out_o[63:32], 32'hFFFF_FFFF);
    chk("t6_health", health_o, 8'h04);
    post(3, 64'd60, 32'd2);
    step(1);
    req_i = '0;
    expect_start("t7", 60, 2);
`else
    seen = 1'b0;
    for (i = 0; i < 200; i++) begin
      step(1);
      if (ready_o !== 4'b0000) seen = 1'b1;
    end
    chk("t6_no_ready", seen, 0);
    chk("t6_start_count", start_cnt - s, 1);
`endif

    // Reset in the middle of WAIT, then a stray completion.
    step(3);
    reset_n_i = 1'b0;
    #1;
    chk("t7_rst_start", div_start_o, 0);
    chk("t7_rst_ready", ready_o, 0);
    chk("t7_rst_out", out_o, 0);
    chk("t7_rst_health", health_o, 0);
    chk("t7_rst_num", div_num_o, 0);
    step(1);
    reset_n_i = 1'b1;
    step(1);
    s = start_cnt;
    div_done_i = 1'b1;
    div_quot_i = 32'd77;
    step(1);
    div_done_i = 1'b0;
    div_quot_i = '0;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step(1);
      if (ready_o !== 4'b0000) seen = 1'b1;
    end
    chk("t7_stray_ready", seen, 0);
    chk("t7_stray_out", out_o, 0);
    chk("t7_stray_start", start_cnt - s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
